// File: rtl/health_bar_renderer.sv
// Redraws the boss HP bar one pixel per clock whenever the displayed length changes; blacks it out on defeat.
// Latency: first plot the cycle after leaving IDLE, 480 pixels per pass, done one cycle after the last pixel.
module health_bar_renderer #(
    parameter int       X0           = 20,
    parameter int       Y0           = 10,
    parameter int       MAX_LEN      = 60,
    parameter int       CELL_W       = 2,
    parameter int       BAR_H        = 4,
    parameter bit [2:0] FILL_COLOUR  = 3'b010,
    parameter bit [2:0] EMPTY_COLOUR = 3'b100
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [5:0] health_length,
    input  logic       boss_defeated,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE, HALT} state_t;

    localparam logic [5:0] MAX_LEN6 = 6'(MAX_LEN);
    localparam logic [7:0] PX_LAST  = 8'(MAX_LEN * CELL_W - 1);
    localparam logic [6:0] PY_LAST  = 7'(BAR_H - 1);

    state_t     state, state_nxt;
    logic [7:0] px;
    logic [6:0] py;
    logic [5:0] len_snap;
    logic [5:0] drawn_len;
    logic       pending;
    logic       dead;
    logic       erase;

    logic [5:0] len_clamped;
    logic [7:0] fill_w;
    logic       start;
    logic       last_px;

    // Compare clamped lengths so an out-of-range input does not retrigger passes forever.
    assign len_clamped = (health_length > MAX_LEN6) ? MAX_LEN6 : health_length;
    assign fill_w      = {2'b00, len_snap} * 8'(CELL_W);
    assign start       = dead | pending | (len_clamped != drawn_len);
    assign last_px     = (px == PX_LAST) && (py == PY_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = DRAW;
            DRAW: if (last_px) state_nxt = DONE;
            DONE: state_nxt = erase ? HALT : IDLE;
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        plot   = 1'b0;
        done   = 1'b0;
        x      = 8'd0;
        y      = 7'd0;
        colour = 3'b000;
        busy   = (state == DRAW) || (state == DONE);
        if (state == DRAW) begin
            plot = 1'b1;
            x    = 8'(X0) + px;
            y    = 7'(Y0) + py;
            if (!erase)
                colour = (px < fill_w) ? FILL_COLOUR : EMPTY_COLOUR;
        end
        if (state == DONE)
            done = 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            px        <= 8'd0;
            py        <= 7'd0;
            len_snap  <= 6'd0;
            drawn_len <= 6'd0;
            pending   <= 1'b1;
            dead      <= 1'b0;
            erase     <= 1'b0;
        end else begin
            state <= state_nxt;
            dead  <= dead | boss_defeated;
            case (state)
                IDLE: begin
                    if (start) begin
                        px       <= 8'd0;
                        py       <= 7'd0;
                        pending  <= 1'b0;
                        len_snap <= len_clamped;
                        erase    <= dead;
                    end
                end
                DRAW: begin
                    // The snapshot is held for the whole pass; a change only queues another pass.
                    if (len_clamped != len_snap)
                        pending <= 1'b1;
                    if (px == PX_LAST) begin
                        px <= 8'd0;
                        py <= py + 7'd1;
                    end else begin
                        px <= px + 8'd1;
                    end
                end
                DONE: drawn_len <= len_snap;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_health_bar_renderer.sv
// Scoreboard bench for health_bar_renderer: stimulus queues expected pixels, a monitor checks every plot.
module tb_health_bar_renderer;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [5:0] health_length;
    logic       boss_defeated;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    health_bar_renderer dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .health_length (health_length),
        .boss_defeated (boss_defeated),
        .x             (x),
        .y             (y),
        .colour        (colour),
        .plot          (plot),
        .busy          (busy),
        .done          (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   plot_cnt = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   last_gap = 0;
    logic prev_plot = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected bar: fill for columns below len*2, empty colour beyond, black for an erase pass.
    task automatic push_pass(input int len, input bit erase);
        pix_t p;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 120; c++) begin
                p.x = 8'(20 + c);
                p.y = 7'(10 + r);
                p.c = erase ? 3'b000 : ((c < len * 2) ? 3'b010 : 3'b100);
                sb.push_back(p);
            end
    endtask

    always @(negedge CLOCK_50) begin
        pix_t e;
        cyc++;
        check("busy_vs_activity", int'(busy), int'(plot | done));
        if (plot) begin
            if (!prev_plot) last_gap = cyc - last_done_cyc;
            plot_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_plot: got pixel (%0d,%0d) colour %0d, expected no plot", x, y, colour);
            end else begin
                e = sb.pop_front();
                tests++;
                if ({x, y, colour} != e) begin
                    fails++;
                    $display("FAIL pixel: got (%0d,%0d) colour %0d, expected (%0d,%0d) colour %0d",
                             x, y, colour, e.x, e.y, e.c);
                end
            end
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        prev_plot = plot;
    end

    task automatic wait_done(input int target, input string name);
        int t = 0;
        while (done_cnt < target && t < 3000) begin
            @(posedge CLOCK_50);
            #1;
            t++;
        end
        check({name, "_done"}, int'(done_cnt >= target), 1);
        check({name, "_queue_drained"}, sb.size(), 0);
    endtask

    task automatic wait_plots(input int target, input string name);
        int t = 0;
        while (plot_cnt < target && t < 3000) begin
            @(posedge CLOCK_50);
            #1;
            t++;
        end
        check({name, "_reached"}, int'(plot_cnt >= target), 1);
    endtask

    task automatic idle_check(input int n, input string name);
        int p0 = plot_cnt;
        repeat (n) @(posedge CLOCK_50);
        #1;
        check(name, plot_cnt - p0, 0);
    endtask

    initial begin
        int p0;
        reset         = 1'b1;
        health_length = 6'd60;
        boss_defeated = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_plot", int'(plot), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_xy", int'({x, y, colour}), 0);

        // Power-up draw at full health
        push_pass(60, 1'b0);
        reset = 1'b0;
        wait_done(1, "powerup");
        check("powerup_plots", plot_cnt, 480);
        idle_check(50, "powerup_idle");

        // Single decrement
        p0 = plot_cnt;
        health_length = 6'd59;
        push_pass(59, 1'b0);
        wait_done(2, "decrement");
        check("decrement_plots", plot_cnt - p0, 480);
        idle_check(50, "decrement_idle");

        // Change mid-pass: 60 -> 59, then 58 at pixel 100
        health_length = 6'd60;
        push_pass(60, 1'b0);
        wait_done(3, "restore");
        p0 = plot_cnt;
        push_pass(59, 1'b0);
        push_pass(58, 1'b0);
        health_length = 6'd59;
        wait_plots(p0 + 100, "midpass_pixel100");
        health_length = 6'd58;
        wait_done(5, "midpass");
        check("midpass_plots", plot_cnt - p0, 960);
        check("midpass_restart_gap", last_gap, 2);
        idle_check(50, "midpass_idle");

        // Defeat while idle at length 1
        health_length = 6'd1;
        push_pass(1, 1'b0);
        wait_done(6, "len1");
        push_pass(0, 1'b1);
        boss_defeated = 1'b1;
        @(posedge CLOCK_50);
        #1;
        boss_defeated = 1'b0;
        wait_done(7, "blackout");
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("halt_busy", int'(busy), 0);
        p0 = plot_cnt;
        for (int i = 0; i < 2000; i++) begin
            health_length = 6'(i % 64);
            @(posedge CLOCK_50);
            #1;
        end
        check("halt_plots", plot_cnt - p0, 0);
        check("halt_done_count", done_cnt, 7);
        check("halt_busy_end", int'(busy), 0);

        // Clamp of out-of-range length
        reset = 1'b1;
        health_length = 6'd63;
        repeat (2) @(posedge CLOCK_50);
        #1;
        sb.delete();
        push_pass(60, 1'b0);
        reset = 1'b0;
        wait_done(8, "clamp");
        idle_check(50, "clamp_idle");

        // Reset in the middle of a pass
        health_length = 6'd30;
        push_pass(30, 1'b0);
        p0 = plot_cnt;
        wait_plots(p0 + 200, "reset_mid_pixel200");
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("reset_mid_plot", int'(plot), 0);
        check("reset_mid_busy", int'(busy), 0);
        check("reset_mid_done", int'(done), 0);
        sb.delete();
        repeat (2) @(posedge CLOCK_50);
        #1;
        push_pass(30, 1'b0);
        p0 = plot_cnt;
        reset = 1'b0;
        wait_done(9, "reset_restart");
        check("reset_restart_plots", plot_cnt - p0, 480);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
